serial_subtractor: RTL

Multi-cycle 128-bit unsigned/two's-complement subtractor. Computes diff = a - b one DIGIT_W-bit digit per cycle, LSB digit first, with a registered borrow chain. It is the subtract-direction counterpart to the adder datapath and feeds the ALU's SUB/CMP path when area matters more than latency. Valid/ready handshake on both the input side and the output side.

---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/serial_subtractor_digit.sv | 25 ++
 rtl/serial_subtractor.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor: FSM state encoding and
// the helpers that size the digit counter.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT_W-bit digits in a WIDTH-bit operand.
  function automatic int n_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

  // Counter width $clog2(N), kept at least 1 bit so a single-digit
  // configuration still has a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_digit.sv
// One digit of the serial subtractor: a DIGIT_W-bit ripple of 1-bit full
// subtractors computing {borrow_out, d} = a - b - borrow_in.
module digit_subtractor #(
  parameter int DIGIT_W = 8
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               borrow_in,
  output logic [DIGIT_W-1:0] d,
  output logic               borrow_out
);

  logic [DIGIT_W:0] bchain;

  assign bchain[0] = borrow_in;

  // Full subtractor per bit: borrow out when a < b + borrow_in at this bit.
  for (genvar i = 0; i < DIGIT_W; i++) begin : g_fs
    assign d[i]          = a[i] ^ b[i] ^ bchain[i];
    assign bchain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bchain[i]);
  end

  assign borrow_out = bchain[DIGIT_W];

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one DIGIT_W-bit digit per cycle, LSB
// digit first, with a registered borrow chain and valid/ready on both sides.
// Optional build macro SERIAL_SUBTRACTOR_FLAGS_EN adds zero/neg/ovf flags.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH   = 128,
  parameter int DIGIT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  ,
  output logic             zero_flag,
  output logic             neg_flag,
  output logic             ovf_flag
`endif
);

  localparam int N  = n_digits(WIDTH, DIGIT_W);
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH % DIGIT_W != 0) begin : g_width_check
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT_W");
  end

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   res_q;
  logic               borrow_out_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [DIGIT_W-1:0] dig_d;
  logic               dig_bo;
  logic [WIDTH-1:0]   res_d;

  // The single digit slice, reused every RUN cycle on the low digit.
  digit_subtractor #(.DIGIT_W(DIGIT_W)) u_digit (
    .a          (a_sh_q[DIGIT_W-1:0]),
    .b          (b_sh_q[DIGIT_W-1:0]),
    .borrow_in  (borrow_q),
    .d          (dig_d),
    .borrow_out (dig_bo)
  );

  // New digit enters the result register at the MSB end.
  assign res_d = (res_q >> DIGIT_W) | (WIDTH'(dig_d) << (WIDTH - DIGIT_W));

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  logic sign_a_q, sign_b_q, zacc_q;
  logic zero_flag_q, neg_flag_q, ovf_flag_q;
`endif

  // Control FSM and datapath registers, all with registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      borrow_out_q <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      zacc_q       <= 1'b0;
      zero_flag_q  <= 1'b0;
      neg_flag_q   <= 1'b0;
      ovf_flag_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            borrow_q   <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            sign_a_q   <= a[WIDTH-1];
            sign_b_q   <= b[WIDTH-1];
            zacc_q     <= 1'b1;
`endif
          end
        end
        RUN: begin
          a_sh_q   <= a_sh_q >> DIGIT_W;
          b_sh_q   <= b_sh_q >> DIGIT_W;
          res_q    <= res_d;
          borrow_q <= dig_bo;
          cnt_q    <= cnt_q + 1'b1;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
          zacc_q   <= zacc_q & (dig_d == '0);
`endif
          if (cnt_q == LAST) begin
            borrow_out_q <= dig_bo;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
            zero_flag_q  <= zacc_q & (dig_d == '0);
            neg_flag_q   <= dig_d[DIGIT_W-1];
            ovf_flag_q   <= (sign_a_q != sign_b_q) &&
                            (dig_d[DIGIT_W-1] != sign_a_q);
`endif
          end
        end
        DONE: begin
          if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign diff       = res_q;
  assign borrow_out = borrow_out_q;

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
  assign zero_flag = zero_flag_q;
  assign neg_flag  = neg_flag_q;
  assign ovf_flag  = ovf_flag_q;
`endif

endmodule
